// File: rtl/vga_scan_controller.sv
// vga_scan_controller
// Raster timing generator for a 640x480@60 display. It produces the
// row-major frame-buffer address, latches the effect code at frame
// boundaries only, and re-aligns sync/blanking with the processed pixel
// that returns PIPE_LAT pixel ticks after its address was issued.
module vga_scan_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [2:0]  mode_req,
   input  logic [11:0] ripe_color,
   output logic [18:0] picture_addr,
   output logic [2:0]  state_info,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [18:0]   LAST_ADDR  = 19'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [2:0]    MODE_RESET = 3'b110;

   logic [HW-1:0]       h_cnt;
   logic [VW-1:0]       v_cnt;
   logic [18:0]         addr_cnt;
   logic                h_wrap;
   logic                frame_wrap;
   logic                act;
   logic                hs_raw;
   logic                vs_raw;
   logic [PIPE_LAT-1:0] act_d;
   logic [PIPE_LAT-1:0] hs_d;
   logic [PIPE_LAT-1:0] vs_d;

   // Decode raster position: wraps, active window and raw (undelayed) syncs.
   always_comb begin
      h_wrap     = (h_cnt == H_LAST);
      frame_wrap = pix_en && h_wrap && (v_cnt == V_LAST);
      act        = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_raw     = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
      vs_raw     = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
   end

   // Horizontal and vertical position counters, advancing one pixel per tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   // Incremental row-major address: steps on active pixels, saturates on the
   // last pixel so it holds through vertical blanking, clears at frame wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_cnt <= 19'd0;
      end else if (pix_en) begin
         if (frame_wrap) begin
            addr_cnt <= 19'd0;
         end else if (act && (addr_cnt != LAST_ADDR)) begin
            addr_cnt <= addr_cnt + 19'd1;
         end
      end
   end

   assign picture_addr = addr_cnt;

   // Delay line matching the buffer-read plus core latency for act and syncs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_d <= '0;
         hs_d  <= '1;
         vs_d  <= '1;
      end else if (pix_en) begin
         act_d[0] <= act;
         hs_d[0]  <= hs_raw;
         vs_d[0]  <= vs_raw;
         for (int i = 1; i < PIPE_LAT; i++) begin
            act_d[i] <= act_d[i-1];
            hs_d[i]  <= hs_d[i-1];
            vs_d[i]  <= vs_d[i-1];
         end
      end
   end

   // Pin register: syncs and blank-gated colour leave together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         vga_r <= 4'd0;
         vga_g <= 4'd0;
         vga_b <= 4'd0;
      end else if (pix_en) begin
         hsync <= hs_d[PIPE_LAT-1];
         vsync <= vs_d[PIPE_LAT-1];
         if (act_d[PIPE_LAT-1]) begin
            vga_r <= ripe_color[11:8];
            vga_g <= ripe_color[7:4];
            vga_b <= ripe_color[3:0];
         end else begin
            vga_r <= 4'd0;
            vga_g <= 4'd0;
            vga_b <= 4'd0;
         end
      end
   end

   // Frame-boundary mode latch; frame_start is a single-clk strobe, so it is
   // refreshed every clk rather than held across disabled ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_info  <= MODE_RESET;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_wrap;
         if (frame_wrap) begin
            state_info <= mode_req;
         end
      end
   end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Display-side timing stage wrapped around the pixel-processing core.
- Generates 640x480@60 raster timing and the 19-bit frame-buffer address (picture_addr) that drives the buffer read and the processing core.
- Latches the effect selection (state_info) only at frame boundaries, so a mode change never tears mid-frame.
- Re-aligns the processed pixel (ripe_color) with delayed sync and blanking, and drives the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 2, pixel ticks from picture_addr to a valid ripe_color (buffer read + core register)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel-tick enable; one tick = one pixel (tie high if clk is the pixel clock)
- mode_req  input  3  requested effect code from the user-input logic
- ripe_color  input  12  processed RGB444 pixel from the processing core
- picture_addr  output  19  frame-buffer read address, row-major: v*H_ACTIVE+h
- state_info  output  3  frame-stable effect code to the processing core
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- vga_r  output  4  red, gated by delayed active-video
- vga_g  output  4  green, gated by delayed active-video
- vga_b  output  4  blue, gated by delayed active-video
- frame_start  output  1  one-clk pulse at the frame wrap

Behaviour:
- Reset (async, while rst=1):
  - h_cnt=0, v_cnt=0, picture_addr=0
  - hsync=1, vsync=1, vga_r/g/b=0
  - frame_start=0, delay line cleared (inactive, syncs high)
  - state_info=3'b110 (pass-through)
- Reset released mid-frame: the raster restarts at (0,0) and no stale colour reaches the pins.
- Counters: all state advances only on clk edges where pix_en=1; with pix_en=0 every register holds.
  - H_TOTAL = sum of the four H parameters = 800; V_TOTAL = sum of the four V parameters = 525.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on the h wrap and counts 0..V_TOTAL-1, wrapping to 0.
- Active video: act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Address generation (incremental, no multiplier):
  - Registered address counter advances by 1 on each active tick.
  - Counter is cleared to 0 on the frame-wrap tick.
  - picture_addr holds during blanking, so it equals v*640+h for every active pixel.
  - Last active pixel is 307199; picture_addr never exceeds 307199.
- Raw sync, combinational from the counters:
  - hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vs_raw low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
- Alignment:
  - act, hs_raw and vs_raw pass through a PIPE_LAT-stage shift register that advances on pix_en.
  - The delayed stage drives hsync, vsync and the colour gate.
  - vga_{r,g,b} <= delayed act ? ripe_color[11:8]/[7:4]/[3:0] : 0, registered on pix_en.
  - Total pin latency from the address tick = PIPE_LAT+1 ticks, for colour and sync alike, so they stay mutually aligned.
- Mode latch:
  - On the frame-wrap tick (pix_en=1, h_cnt=799, v_cnt=524): state_info <= mode_req and frame_start=1 for exactly that clk.
  - frame_start=0 at all other times.
  - mode_req changes at any other time have no effect until the next wrap.
  - A mode_req change on the wrap tick itself is captured.
- Codes: all 3-bit codes are passed unmodified; the processing core defines their meaning.
- No handshake: the downstream buffer and core are required to return ripe_color within PIPE_LAT ticks of picture_addr.

Test Plan:
1. rst pulse mid-line at h=300 -> on the same cycle picture_addr=0, hsync=vsync=1, rgb=0, state_info=3'b110; after release the first pix_en tick gives h_cnt=1.
2. pix_en=1, run one full line -> hsync low exactly 96 ticks, the first low at pin tick 656+PIPE_LAT+1; line period 800 ticks.
3. Full frame -> vsync low for 2 lines starting at line 490 (delayed); picture_addr reaches 307199 at (639,479), then holds through blanking; frame_start pulses once per 420000 ticks.
4. Model ripe_color = picture_addr[11:0] registered twice -> vga_r/g/b equal the address of the matching pixel on every active tick, and 0 on every blank tick.
5. mode_req 110->001 at (100,200) -> state_info stays 110 until the wrap tick, becomes 001 on the same clk as frame_start=1.
6. pix_en every 4th clk -> counters and outputs frozen between enables; timing identical when counted in ticks.
